// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with internal synchronous data memory
// Byte/half/word loads and stores, MEM/WB register, stall/flush and misalignment detection.
module mem_access_stage #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int REG_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_sign,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_w_reg_ena,
  input  logic              ex_wb_sel,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_mem_data,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_w_reg_ena,
  output logic              mem_wb_sel,
  output logic              mem_addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            off;
  logic                  mis_cond;
  logic                  misaligned;
  logic                  accept;
  logic [DATA_W-1:0]     wr_data;
  logic [3:0]            wr_be;

  logic [DATA_W-1:0]     rd_word;
  logic [1:0]            rd_off;
  logic [1:0]            rd_size;
  logic                  rd_sign;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  assign idx    = ex_alu_res[DEPTH_LOG2+1:2];
  assign off    = ex_alu_res[1:0];
  assign accept = ex_valid & ~stall & ~flush;

  always_comb begin
    mis_cond = 1'b0;
    case (ex_mem_size)
      2'b00:   mis_cond = 1'b0;
      2'b01:   mis_cond = off[0];
      default: mis_cond = (off != 2'b00);
    endcase
  end

  assign misaligned = ex_valid & (ex_mem_rd | ex_mem_wr) & mis_cond;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    wr_data = ex_rt_data;
    wr_be   = 4'b1111;
    case (ex_mem_size)
      2'b00: begin
        wr_data = {4{ex_rt_data[7:0]}};
        wr_be   = 4'b0001 << off;
      end
      2'b01: begin
        wr_data = {2{ex_rt_data[15:0]}};
        wr_be   = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_data = ex_rt_data;
        wr_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && ex_mem_wr && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid     <= 1'b0;
      mem_alu_res   <= '0;
      mem_rd        <= '0;
      mem_w_reg_ena <= 1'b0;
      mem_wb_sel    <= 1'b0;
      mem_addr_err  <= 1'b0;
      rd_word       <= '0;
      rd_off        <= 2'b00;
      rd_size       <= 2'b00;
      rd_sign       <= 1'b0;
    end else if (flush) begin
      mem_valid     <= 1'b0;
      mem_w_reg_ena <= 1'b0;
      mem_addr_err  <= 1'b0;
    end else if (!stall) begin
      mem_valid     <= ex_valid;
      mem_alu_res   <= ex_alu_res;
      mem_rd        <= ex_rd;
      mem_w_reg_ena <= ex_w_reg_ena & ex_valid & ~misaligned;
      mem_wb_sel    <= ex_wb_sel;
      mem_addr_err  <= misaligned;
      if (ex_valid && ex_mem_rd) begin
        rd_word <= mem[idx];
        rd_off  <= off;
        rd_size <= ex_mem_size;
        rd_sign <= ex_mem_sign;
      end
    end
  end

  // Lane select and extension stay after the read register so WB sees settled data.
  assign lane_b = 8'(rd_word >> {rd_off, 3'b000});
  assign lane_h = rd_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    mem_mem_data = rd_word;
    case (rd_size)
      2'b00:   mem_mem_data = {{(DATA_W-8){rd_sign & lane_b[7]}}, lane_b};
      2'b01:   mem_mem_data = {{(DATA_W-16){rd_sign & lane_h[15]}}, lane_h};
      default: mem_mem_data = rd_word;
    endcase
  end

endmodule
